min_search: RTL and testbench
=============================

MIN_SEARCH -- requirements
Module: min_search

Interface
REQ-001 The module SHALL have parameter BIT_WIDTH, default 14, which sets the width of one candidate cost (SAD) value.
REQ-002 The module SHALL have parameter LANES, default 4, giving candidates per input beat; it SHALL be a power of two, 1..16.
REQ-003 The module SHALL have parameter INDEX_WIDTH, default 8, giving the width of the candidate index; it SHALL be at least log2(LANES)+1.
REQ-004 Port clk SHALL be an input, 1 bit: the single clock; every flop is rising-edge triggered.
REQ-005 Port rst SHALL be an input, 1 bit: reset, asynchronous and active-high.
REQ-006 Port in_valid SHALL be an input, 1 bit: an input beat is presented.
REQ-007 Port in_ready SHALL be an output, 1 bit: the beat is accepted when in_valid and in_ready are both high.
REQ-008 Port in_last SHALL be an input, 1 bit: this beat is the final beat of a search.
REQ-009 Port in_data SHALL be an input, LANES*BIT_WIDTH bits: lane k occupies bits [k*BIT_WIDTH +: BIT_WIDTH].
REQ-010 Port out_valid SHALL be an output, 1 bit: a search result is presented.
REQ-011 Port out_ready SHALL be an input, 1 bit: the result is consumed when out_valid and out_ready are both high.
REQ-012 Port out_element SHALL be an output, BIT_WIDTH bits: the minimum cost of the search.
REQ-013 Port out_index SHALL be an output, INDEX_WIDTH bits: the global candidate index of the minimum.
REQ-014 Port out_overflow SHALL be an output, 1 bit: the search contained more than 2^INDEX_WIDTH candidates.

Function
REQ-015 The global index of lane k in beat b SHALL be b*LANES+k; b SHALL restart at 0 after each in_last beat.
REQ-016 On a cost tie, the lower global index SHALL win, both within a beat and across beats.
REQ-017 Stage 1 SHALL register the lane-minimum of each accepted beat, its lane index and in_last.
REQ-018 Stage 2 SHALL hold the running minimum; the first beat of a search SHALL load it unconditionally, and later beats SHALL replace it only on a strictly smaller cost.
REQ-019 The FSM SHALL have two states: ACCUM and RESULT. ACCUM SHALL move to RESULT when stage 2 absorbs a beat with last set. RESULT SHALL move back to ACCUM on the out_valid&&out_ready handshake.
REQ-020 Latency SHALL be fixed: an in_last beat accepted at cycle t SHALL give out_valid high at cycle t+2.
REQ-021 in_ready SHALL be high only in ACCUM while stage 1 does not hold a last beat.
REQ-022 in_ready SHALL NOT depend combinationally on out_ready.
REQ-023 out_valid SHALL be high only in RESULT.
REQ-024 out_element, out_index and out_overflow SHALL stay stable while out_valid is high and out_ready is low.
REQ-025 The beat counter SHALL saturate at its maximum rather than wrap; reaching saturation SHALL set a sticky overflow flag for the current search.
REQ-026 When the overflow flag is set, no further candidate SHALL update the running minimum.
REQ-027 A single-beat search (first beat has in_last set) SHALL be legal.
REQ-028 Beats may arrive with idle cycles between them, and the result SHALL be unaffected.
REQ-029 Comparisons SHALL be unsigned; no arithmetic wider than BIT_WIDTH SHALL be needed.

Reset
REQ-030 Asserting rst SHALL immediately drive out_valid=0, out_element=0, out_index=0, out_overflow=0 and state=ACCUM.
REQ-031 Asserting rst SHALL clear stage-1 valid, the beat counter and the overflow flag.
REQ-032 A reset during a search SHALL discard that search; the first beat after reset SHALL start a new search at index 0.

Configuration
REQ-033 With macro MIN_SEARCH_MASK_EN defined, the module SHALL add input in_mask (LANES bits; 1 = lane excluded).
REQ-034 With MIN_SEARCH_MASK_EN defined, an excluded lane SHALL never be selected.
REQ-035 With MIN_SEARCH_MASK_EN defined, the module SHALL add output out_none (1 bit), high when every candidate in the search was excluded; out_element SHALL then be all ones and out_index 0.
REQ-036 Without MIN_SEARCH_MASK_EN, in_mask and out_none SHALL be absent and all lanes SHALL be eligible.

Structure
REQ-037 Package min_search_pkg SHALL hold the state enum (ACCUM, RESULT), the all-ones cost constant and a lane-index width function.
REQ-038 The combinational LANES-input argmin SHALL be sub-module min_tree: a log2(LANES)-level tree of 2-input compare/select cells that carries index bits, lower index winning on ties.

Verification
REQ-039 Verify LANES=4 with one beat {9,3,7,3} and last=1: result out_element=3, out_index=1, out_valid at t+2.
REQ-040 Verify a 3-beat search with global minimum 5 at indices 6 and 10: result out_index=6.
REQ-041 Verify out_ready held low 10 cycles at the result: outputs stable, in_ready=0 throughout, next search accepted after the handshake.
REQ-042 Verify INDEX_WIDTH=4, LANES=4 with 5 beats: out_overflow=1 and only beats 0..3 are considered.
REQ-043 Verify rst pulsed between beat 1 and beat 2 of a search: no result for that search; a following 1-beat search {1,1,1,1} gives out_index=0.
REQ-044 Verify, with MIN_SEARCH_MASK_EN, mask=4'b0010 on {8,2,9,9}: out_element=8, out_index=0; a fully masked search gives out_none=1.

Source files
------------

// File: rtl/min_search_pkg.sv
// Shared types and helpers for the min_search block: FSM state encoding,
// the all-ones cost constant and the lane-index width helper.
package min_search_pkg;

  typedef enum logic {
    ACCUM  = 1'b0,
    RESULT = 1'b1
  } state_e;

  // Wide enough for any practical BIT_WIDTH; users slice the low bits.
  localparam int unsigned COST_MAX_W = 64;
  localparam logic [COST_MAX_W-1:0] COST_ALL_ONES = '1;

  // A single-lane build still needs a 1-bit lane field.
  function automatic int lane_idx_w(input int lanes);
    return (lanes > 1) ? $clog2(lanes) : 1;
  endfunction

endpackage

// File: rtl/min_tree.sv
// Combinational LANES-input argmin: a log2(LANES)-level tree of 2-input
// compare/select cells carrying the lane index and an eligibility bit.
module min_tree
  import min_search_pkg::*;
#(
  parameter int BIT_WIDTH = 14,
  parameter int LANES     = 4
) (
  input  logic [LANES*BIT_WIDTH-1:0]     cost_i,
  input  logic [LANES-1:0]               elig_i,
  output logic [BIT_WIDTH-1:0]           min_cost_o,
  output logic [lane_idx_w(LANES)-1:0]   min_lane_o,
  output logic                           any_o
);

  localparam int LW     = lane_idx_w(LANES);
  localparam int LEVELS = $clog2(LANES);

  logic [BIT_WIDTH-1:0] cost_n [LANES];
  logic [LW-1:0]        lane_n [LANES];
  logic                 elig_n [LANES];

  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      cost_n[k] = cost_i[k*BIT_WIDTH +: BIT_WIDTH];
      lane_n[k] = LW'(k);
      elig_n[k] = elig_i[k];
    end
    // Reduced in place: node k of a level is built from nodes 2k and 2k+1.
    for (int lvl = 0; lvl < LEVELS; lvl++) begin
      for (int k = 0; k < (LANES >> (lvl + 1)); k++) begin
        // The right child wins only when strictly cheaper, so ties keep the lower index.
        if (elig_n[2*k+1] && (!elig_n[2*k] || (cost_n[2*k+1] < cost_n[2*k]))) begin
          cost_n[k] = cost_n[2*k+1];
          lane_n[k] = lane_n[2*k+1];
          elig_n[k] = 1'b1;
        end else begin
          cost_n[k] = cost_n[2*k];
          lane_n[k] = lane_n[2*k];
          elig_n[k] = elig_n[2*k];
        end
      end
    end
    min_cost_o = cost_n[0];
    min_lane_o = lane_n[0];
    any_o      = elig_n[0];
  end

endmodule

// File: rtl/min_search.sv
// Streaming minimum search over multi-lane cost beats: stage 1 registers the
// lane minimum, stage 2 keeps the running minimum. Optional lane masking
// is enabled by defining MIN_SEARCH_MASK_EN.
module min_search
  import min_search_pkg::*;
#(
  parameter int BIT_WIDTH   = 14,
  parameter int LANES       = 4,
  parameter int INDEX_WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         in_last,
  input  logic [LANES*BIT_WIDTH-1:0]   in_data,
`ifdef MIN_SEARCH_MASK_EN
  input  logic [LANES-1:0]             in_mask,
  output logic                         out_none,
`endif
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [BIT_WIDTH-1:0]         out_element,
  output logic [INDEX_WIDTH-1:0]       out_index,
  output logic                         out_overflow,
  output state_e                       dbg_state_o
);

  // Handshakes: a transfer happens on a rising clk edge where valid and ready
  // are both high; valid holds its payload until then, and in_ready is a
  // function of registered state only (never of out_ready).

  localparam int LW    = lane_idx_w(LANES);
  localparam int LOG2L = $clog2(LANES);
  localparam int CW    = INDEX_WIDTH - LOG2L;
  localparam logic [BIT_WIDTH-1:0] ONES    = COST_ALL_ONES[BIT_WIDTH-1:0];
  localparam logic [CW:0]          CNT_SAT = {1'b1, {CW{1'b0}}};

  logic [LANES-1:0]     elig;
  logic [BIT_WIDTH-1:0] tree_cost;
  logic [LW-1:0]        tree_lane;
  logic                 tree_any;
  logic                 accept;

`ifdef MIN_SEARCH_MASK_EN
  assign elig = ~in_mask;
`else
  assign elig = '1;
`endif

  min_tree #(
    .BIT_WIDTH (BIT_WIDTH),
    .LANES     (LANES)
  ) u_tree (
    .cost_i     (in_data),
    .elig_i     (elig),
    .min_cost_o (tree_cost),
    .min_lane_o (tree_lane),
    .any_o      (tree_any)
  );

  // Stage 1: lane minimum of the accepted beat.
  logic                 s1_valid_q, s1_last_q, s1_any_q;
  logic [BIT_WIDTH-1:0] s1_cost_q;
  logic [LW-1:0]        s1_lane_q;

  assign accept = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_any_q   <= 1'b0;
      s1_cost_q  <= '0;
      s1_lane_q  <= '0;
    end else begin
      s1_valid_q <= accept;
      if (accept) begin
        s1_last_q <= in_last;
        s1_any_q  <= tree_any;
        s1_cost_q <= tree_cost;
        s1_lane_q <= tree_lane;
      end
    end
  end

  // Stage 2: running minimum, beat counter and sticky flags.
  state_e                 state_q, state_d;
  logic [BIT_WIDTH-1:0]   min_q, min_d;
  logic [INDEX_WIDTH-1:0] idx_q, idx_d;
  logic                   ovf_q, ovf_d;
  logic                   none_q, none_d;
  logic                   first_q, first_d;
  logic [CW:0]            cnt_q, cnt_d;
  logic [INDEX_WIDTH-1:0] beat_idx;
  logic                   sat_hit, ovf_now;

  assign beat_idx = (INDEX_WIDTH'(cnt_q[CW-1:0]) << LOG2L) | INDEX_WIDTH'(s1_lane_q);
  // The counter parks at 2^CW after the last legal beat; any beat arriving
  // there would exceed 2^INDEX_WIDTH candidates.
  assign sat_hit  = (cnt_q == CNT_SAT);
  assign ovf_now  = (ovf_q && !first_q) || sat_hit;

  always_comb begin
    min_d   = min_q;
    idx_d   = idx_q;
    ovf_d   = ovf_q;
    none_d  = none_q;
    first_d = first_q;
    cnt_d   = cnt_q;
    if (s1_valid_q) begin
      if (first_q) begin
        min_d  = s1_any_q ? s1_cost_q : ONES;
        idx_d  = s1_any_q ? beat_idx : '0;
        none_d = !s1_any_q;
        ovf_d  = 1'b0;
      end else begin
        ovf_d = ovf_now;
        if (!ovf_now && s1_any_q && (none_q || (s1_cost_q < min_q))) begin
          min_d  = s1_cost_q;
          idx_d  = beat_idx;
          none_d = 1'b0;
        end
      end
      first_d = s1_last_q;
      if (s1_last_q) begin
        cnt_d = '0;
      end else if (!sat_hit) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      min_q   <= '0;
      idx_q   <= '0;
      ovf_q   <= 1'b0;
      none_q  <= 1'b0;
      first_q <= 1'b1;
      cnt_q   <= '0;
    end else begin
      min_q   <= min_d;
      idx_q   <= idx_d;
      ovf_q   <= ovf_d;
      none_q  <= none_d;
      first_q <= first_d;
      cnt_q   <= cnt_d;
    end
  end

  // FSM: state register, next-state logic, output logic.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ACCUM;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ACCUM:   if (s1_valid_q && s1_last_q) state_d = RESULT;
      RESULT:  if (out_ready) state_d = ACCUM;
      default: state_d = ACCUM;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == ACCUM) && !(s1_valid_q && s1_last_q);
    out_valid = (state_q == RESULT);
  end

  assign out_element  = min_q;
  assign out_index    = idx_q;
  assign out_overflow = ovf_q;
  assign dbg_state_o  = state_q;
`ifdef MIN_SEARCH_MASK_EN
  assign out_none     = none_q;
`endif

endmodule

// File: tb/tb_min_search.sv
// Directed bench for min_search: a default instance and an INDEX_WIDTH=4
// instance share all inputs so the overflow boundary is seen side by side.
module tb_min_search;
  import min_search_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_last, out_ready;
  logic [55:0] in_data;
  logic        in_ready, out_valid, out_overflow;
  logic [13:0] out_element;
  logic [7:0]  out_index;
  state_e      dbg_state;
  logic        in_ready_s, out_valid_s, out_overflow_s;
  logic [13:0] out_element_s;
  logic [3:0]  out_index_s;
  state_e      dbg_state_s;
`ifdef MIN_SEARCH_MASK_EN
  logic [3:0]  in_mask;
  logic        out_none, out_none_s;
`endif

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  min_search dut (
    .clk (clk), .rst (rst), .in_valid (in_valid), .in_ready (in_ready),
    .in_last (in_last), .in_data (in_data),
`ifdef MIN_SEARCH_MASK_EN
    .in_mask (in_mask), .out_none (out_none),
`endif
    .out_valid (out_valid), .out_ready (out_ready), .out_element (out_element),
    .out_index (out_index), .out_overflow (out_overflow), .dbg_state_o (dbg_state)
  );

  min_search #(.INDEX_WIDTH(4)) dut_s (
    .clk (clk), .rst (rst), .in_valid (in_valid), .in_ready (in_ready_s),
    .in_last (in_last), .in_data (in_data),
`ifdef MIN_SEARCH_MASK_EN
    .in_mask (in_mask), .out_none (out_none_s),
`endif
    .out_valid (out_valid_s), .out_ready (out_ready), .out_element (out_element_s),
    .out_index (out_index_s), .out_overflow (out_overflow_s), .dbg_state_o (dbg_state_s)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_beat(input logic [13:0] l0, input logic [13:0] l1,
                           input logic [13:0] l2, input logic [13:0] l3, input logic last);
    int n = 0;
    @(negedge clk);
    in_data  = {l3, l2, l1, l0};
    in_last  = last;
    in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("in_ready_timeout", in_ready, 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic idle(input int cycles);
    repeat (cycles) @(negedge clk);
  endtask

  // Call right after the last beat was accepted; checks latency, payload, hold, handshake.
  task automatic expect_result(input string tag, input int el, input int idx, input int ovf,
                               input int el_s, input int idx_s, input int ovf_s, input int hold);
    int n;
    @(negedge clk);
    check({tag, "_valid_t1"}, out_valid, 1'b0);
    check({tag, "_in_ready_t1"}, in_ready, 1'b0);
    n = 1;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_latency"}, n, 2);
    check({tag, "_element"}, out_element, el);
    check({tag, "_index"}, out_index, idx);
    check({tag, "_overflow"}, out_overflow, ovf);
    check({tag, "_valid_s"}, out_valid_s, 1'b1);
    check({tag, "_element_s"}, out_element_s, el_s);
    check({tag, "_index_s"}, out_index_s, idx_s);
    check({tag, "_overflow_s"}, out_overflow_s, ovf_s);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, "_hold_valid"}, out_valid, 1'b1);
      check({tag, "_hold_element"}, out_element, el);
      check({tag, "_hold_index"}, out_index, idx);
      check({tag, "_hold_in_ready"}, in_ready, 1'b0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    check({tag, "_valid_after_hs"}, out_valid, 1'b0);
    check({tag, "_in_ready_after_hs"}, in_ready, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
`ifdef MIN_SEARCH_MASK_EN
    in_mask   = 4'b0000;
`endif

    // Reset values
    @(negedge clk);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_element", out_element, 0);
    check("rst_out_index", out_index, 0);
    check("rst_out_overflow", out_overflow, 1'b0);
    check("rst_state", dbg_state, ACCUM);
    check("rst_in_ready", in_ready, 1'b1);
    @(negedge clk);
    rst = 1'b0;

    // Single beat, tie between lanes 1 and 3
    send_beat(14'd9, 14'd3, 14'd7, 14'd3, 1'b1);
    expect_result("single", 3, 1, 0, 3, 1, 0, 0);

    // Three beats, minimum 5 at indices 6 and 10, idle gap before the last beat
    send_beat(14'd20, 14'd30, 14'd40, 14'd50, 1'b0);
    send_beat(14'd8, 14'd12, 14'd5, 14'd9, 1'b0);
    idle(3);
    send_beat(14'd7, 14'd15, 14'd5, 14'd6, 1'b1);
    expect_result("tie_across", 5, 6, 0, 5, 6, 0, 0);

    // Strictly smaller cost in a later beat replaces the minimum
    send_beat(14'd100, 14'd90, 14'd80, 14'd70, 1'b0);
    send_beat(14'd60, 14'd61, 14'd62, 14'd50, 1'b1);
    expect_result("later_wins", 50, 7, 0, 50, 7, 0, 0);

    // All lanes at the maximum cost
    send_beat(14'h3fff, 14'h3fff, 14'h3fff, 14'h3fff, 1'b1);
    expect_result("all_max", 16383, 0, 0, 16383, 0, 0, 0);

    // Back-pressure: out_ready low for 10 cycles, then next search
    send_beat(14'd4, 14'd2, 14'd6, 14'd8, 1'b1);
    expect_result("hold", 2, 1, 0, 2, 1, 0, 10);
    send_beat(14'd5, 14'd5, 14'd1, 14'd5, 1'b1);
    expect_result("after_hold", 1, 2, 0, 1, 2, 0, 0);

    // Exactly 16 candidates: no overflow on the narrow instance
    send_beat(14'd9, 14'd9, 14'd9, 14'd9, 1'b0);
    send_beat(14'd9, 14'd9, 14'd9, 14'd9, 1'b0);
    send_beat(14'd9, 14'd9, 14'd9, 14'd9, 1'b0);
    send_beat(14'd9, 14'd9, 14'd9, 14'd4, 1'b1);
    expect_result("exact16", 4, 15, 0, 4, 15, 0, 0);

    // Five beats: narrow instance overflows and ignores beat 4
    send_beat(14'd50, 14'd40, 14'd30, 14'd20, 1'b0);
    send_beat(14'd60, 14'd61, 14'd62, 14'd63, 1'b0);
    send_beat(14'd19, 14'd70, 14'd70, 14'd70, 1'b0);
    send_beat(14'd70, 14'd70, 14'd70, 14'd18, 1'b0);
    send_beat(14'd1, 14'd70, 14'd70, 14'd70, 1'b1);
    expect_result("overflow", 1, 16, 0, 18, 15, 1, 0);

    // Overflow flag does not leak into the next search
    send_beat(14'd3, 14'd2, 14'd1, 14'd0, 1'b1);
    expect_result("post_ovf", 0, 3, 0, 0, 3, 0, 0);

    // Reset in the middle of a search discards it
    send_beat(14'd10, 14'd11, 14'd12, 14'd13, 1'b0);
    send_beat(14'd14, 14'd15, 14'd16, 14'd17, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_valid", out_valid, 1'b0);
    check("midrst_state", dbg_state, ACCUM);
    check("midrst_element", out_element, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("midrst_no_result", out_valid, 1'b0);
    end
    send_beat(14'd1, 14'd1, 14'd1, 14'd1, 1'b1);
    expect_result("after_rst", 1, 0, 0, 1, 0, 0, 0);

`ifdef MIN_SEARCH_MASK_EN
    // Masked lane 1 must not be selected
    in_mask = 4'b0010;
    send_beat(14'd8, 14'd2, 14'd9, 14'd9, 1'b1);
    expect_result("mask_one", 8, 0, 0, 8, 0, 0, 0);
    check("mask_one_none", out_none, 1'b0);
    // Every lane masked
    in_mask = 4'b1111;
    send_beat(14'd1, 14'd2, 14'd3, 14'd4, 1'b1);
    expect_result("mask_all", 16383, 0, 0, 16383, 0, 0, 0);
    check("mask_all_none", out_none, 1'b1);
    check("mask_all_none_s", out_none_s, 1'b1);
    in_mask = 4'b0000;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
